pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter TIMEOUT, 255: maximum peripheral wait in cycles before forced release; legal range 2..255.
REQ-002 Parameter CNT_W, 16: width of the stall performance counter.
REQ-003 Clock and reset: i_clk is the clock; i_rst_n is the reset, synchronous, active-low.
REQ-004 Ports, one per line (name, direction, width, meaning):
- i_clk  in  1  clock
- i_rst_n  in  1  synchronous active-low reset
- id_rs1_addr, id_rs2_addr  in  5 each  source registers of the instruction in ID
- ex_rd_addr  in  5  destination of the instruction in EX
- ex_rd_wren  in  1  EX instruction writes rd
- ex_mem_rden  in  1  EX instruction is a load
- ex_br_taken  in  1  branch/jump resolved taken in EX
- mem_req  in  1  LSU peripheral access in MEM
- mem_ack  in  1  peripheral access complete
- i_cnt_clr  in  1  clear stall counter
- pc_en  out  1  PC register update enable
- if_id_sel, id_ex_sel, ex_mem_sel, mem_wb_sel  out  2 each  pipeline-register control
- o_mem_timeout  out  1  one-cycle timeout flag
- o_stall_cnt  out  CNT_W  stall-cycle count

Function
REQ-005 Sel encoding: 2'b00 load, 2'b11 clear, 2'b01 hold; block never drives 2'b10.
REQ-006 States: S_RUN, S_MEM_WAIT; 8-bit wait_cnt.
REQ-007 Sel outputs and pc_en: combinational from state and current inputs, sampled by pipeline registers at next edge.
REQ-008 Hazard priority, highest first: peripheral wait, branch flush, load-use.
REQ-009 Peripheral wait active when (S_RUN and mem_req and !mem_ack) or (S_MEM_WAIT and !mem_ack and wait_cnt != TIMEOUT).
REQ-010 Peripheral wait outputs:
- pc_en=0
- if_id_sel, id_ex_sel, ex_mem_sel = 01
- mem_wb_sel=11
REQ-011 S_RUN with mem_req and !mem_ack: next state S_MEM_WAIT, wait_cnt<=1.
REQ-012 S_RUN with mem_req and mem_ack in the same cycle: no stall.
REQ-013 S_MEM_WAIT without mem_ack and wait_cnt<TIMEOUT: wait_cnt increments.
REQ-014 S_MEM_WAIT with mem_ack: release, next state S_RUN, wait_cnt<=0; the lower-priority rules apply in that cycle as in S_RUN.
REQ-015 S_MEM_WAIT with wait_cnt==TIMEOUT and !mem_ack (timeout release):
- o_mem_timeout=1 that cycle only
- mem_wb_sel=11, bubbling the failed access
- other outputs per lower-priority rules
- next state S_RUN
REQ-016 Branch flush: no peripheral wait and ex_br_taken=1 gives:
- pc_en=1
- if_id_sel, id_ex_sel = 11
- ex_mem_sel, mem_wb_sel = 00
REQ-017 Load-use: no peripheral wait, ex_br_taken=0, and the hazard condition below; outputs:
- pc_en=0
- if_id_sel=01
- id_ex_sel=11
- ex_mem_sel, mem_wb_sel = 00
REQ-018 Load-use hazard condition: ex_mem_rden and ex_rd_wren and ex_rd_addr!=0 and (ex_rd_addr==id_rs1_addr or ex_rd_addr==id_rs2_addr).
REQ-019 Register x0: ex_rd_addr==0 never produces a load-use stall.
REQ-020 No hazard: pc_en=1 and all sels 00.
REQ-021 Simultaneous load-use and taken branch: branch flush wins; no stall.
REQ-022 o_stall_cnt:
- increments each cycle with pc_en=0 outside reset
- saturates at all-ones
- i_cnt_clr sets it to 0, taking precedence over increment

Reset
REQ-023 While i_rst_n=0, outputs are:
- all sels 11
- pc_en=0
- o_mem_timeout=0
REQ-024 Reset registers: state<=S_RUN, wait_cnt<=0, o_stall_cnt<=0.
REQ-025 Reset asserted during S_MEM_WAIT abandons the wait; first cycle after deassertion is S_RUN with no-hazard outputs given idle inputs.

Verification
REQ-026 Load-use stall:
- stimulus: ex_mem_rden=1, ex_rd_wren=1, ex_rd_addr=5, id_rs2_addr=5 for one cycle
- response: pc_en=0, if_id_sel=01, id_ex_sel=11, o_stall_cnt +1; next cycle inputs idle -> all 00
REQ-027 x0 exemption: same stimulus as REQ-026 with ex_rd_addr=0 and id_rs1_addr=0 -> pc_en=1, all sels 00.
REQ-028 Branch beats load-use: ex_br_taken=1 with a load-use match -> pc_en=1, if_id_sel=id_ex_sel=11, ex_mem_sel=mem_wb_sel=00.
REQ-029 Acked peripheral wait:
- stimulus: mem_req=1 at cycle 0, mem_ack=1 at cycle 3
- response: cycles 0-2 pc_en=0, first three sels 01, mem_wb_sel=11
- cycle 3: all sels 00
- o_stall_cnt=3
REQ-030 Timeout (TIMEOUT=4):
- stimulus: mem_req=1 held, mem_ack=0
- response: cycles 0-3 stall; cycle 4 o_mem_timeout=1, mem_wb_sel=11, pc_en=1; cycle 5 state S_RUN
REQ-031 Reset mid-wait: i_rst_n=0 at wait cycle 2 -> all sels 11, pc_en=0; after release with idle inputs -> all sels 00, o_stall_cnt=0.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: peripheral-wait stall with timeout, branch flush and
// load-use interlock, driving the pipeline-register select lines and a stall counter.
module pipe_hazard_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [4:0]       id_rs1_addr,
  input  logic [4:0]       id_rs2_addr,
  input  logic [4:0]       ex_rd_addr,
  input  logic             ex_rd_wren,
  input  logic             ex_mem_rden,
  input  logic             ex_br_taken,
  input  logic             mem_req,
  input  logic             mem_ack,
  input  logic             i_cnt_clr,
  output logic             pc_en,
  output logic [1:0]       if_id_sel,
  output logic [1:0]       id_ex_sel,
  output logic [1:0]       ex_mem_sel,
  output logic [1:0]       mem_wb_sel,
  output logic             o_mem_timeout,
  output logic [CNT_W-1:0] o_stall_cnt
);

  localparam logic [0:0] S_RUN      = 1'b0;
  localparam logic [0:0] S_MEM_WAIT = 1'b1;

  localparam logic [1:0] SEL_LOAD  = 2'b00;
  localparam logic [1:0] SEL_HOLD  = 2'b01;
  localparam logic [1:0] SEL_CLEAR = 2'b11;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  logic [0:0]       state_reg;
  logic [0:0]       state_next;
  logic [7:0]       wait_cnt_reg;
  logic [7:0]       wait_cnt_next;
  logic [CNT_W-1:0] stall_cnt_reg;

  logic in_wait;
  logic mem_stall;
  logic mem_timeout;
  logic load_use;

  assign in_wait = (state_reg == S_MEM_WAIT);

  always_comb begin
    mem_stall   = (!in_wait && mem_req && !mem_ack) ||
                  (in_wait && !mem_ack && (wait_cnt_reg != TIMEOUT_CNT));
    mem_timeout = in_wait && !mem_ack && (wait_cnt_reg == TIMEOUT_CNT);
    // x0 is hardwired zero, so a load targeting it can never create a dependency
    load_use    = ex_mem_rden && ex_rd_wren && (ex_rd_addr != 5'd0) &&
                  ((ex_rd_addr == id_rs1_addr) || (ex_rd_addr == id_rs2_addr));
  end

  always_comb begin
    pc_en         = 1'b1;
    if_id_sel     = SEL_LOAD;
    id_ex_sel     = SEL_LOAD;
    ex_mem_sel    = SEL_LOAD;
    mem_wb_sel    = SEL_LOAD;
    o_mem_timeout = 1'b0;
    if (!i_rst_n) begin
      pc_en      = 1'b0;
      if_id_sel  = SEL_CLEAR;
      id_ex_sel  = SEL_CLEAR;
      ex_mem_sel = SEL_CLEAR;
      mem_wb_sel = SEL_CLEAR;
    end else begin
      if (mem_stall) begin
        pc_en      = 1'b0;
        if_id_sel  = SEL_HOLD;
        id_ex_sel  = SEL_HOLD;
        ex_mem_sel = SEL_HOLD;
        mem_wb_sel = SEL_CLEAR;
      end else if (ex_br_taken) begin
        if_id_sel = SEL_CLEAR;
        id_ex_sel = SEL_CLEAR;
      end else if (load_use) begin
        pc_en     = 1'b0;
        if_id_sel = SEL_HOLD;
        id_ex_sel = SEL_CLEAR;
      end
      // A timed-out access still bubbles MEM/WB even when lower rules set the rest
      if (mem_timeout) begin
        mem_wb_sel    = SEL_CLEAR;
        o_mem_timeout = 1'b1;
      end
    end
  end

  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    case (state_reg)
      S_RUN: begin
        if (mem_req && !mem_ack) begin
          state_next    = S_MEM_WAIT;
          wait_cnt_next = 8'd1;
        end
      end
      S_MEM_WAIT: begin
        if (mem_ack || (wait_cnt_reg == TIMEOUT_CNT)) begin
          state_next    = S_RUN;
          wait_cnt_next = 8'd0;
        end else begin
          wait_cnt_next = wait_cnt_reg + 8'd1;
        end
      end
      default: begin
        state_next    = S_RUN;
        wait_cnt_next = 8'd0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_reg    <= S_RUN;
      wait_cnt_reg <= 8'd0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      stall_cnt_reg <= '0;
    end else if (i_cnt_clr) begin
      stall_cnt_reg <= '0;
    end else if (!pc_en && (stall_cnt_reg != {CNT_W{1'b1}})) begin
      stall_cnt_reg <= stall_cnt_reg + 1'b1;
    end
  end

  assign o_stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed-vector bench for pipe_hazard_ctrl: driver queues hand-computed expectations,
// a negedge monitor pops and compares them against the DUT each cycle.
module tb_pipe_hazard_ctrl;

  localparam logic [7:0] NOH = 8'b00_00_00_00;
  localparam logic [7:0] RST = 8'b11_11_11_11;
  localparam logic [7:0] LU  = 8'b01_11_00_00;
  localparam logic [7:0] BR  = 8'b11_11_00_00;
  localparam logic [7:0] MW  = 8'b01_01_01_11;
  localparam logic [7:0] TO  = 8'b00_00_00_11;
  localparam logic [7:0] TOB = 8'b11_11_00_11;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] rs1, rs2, rd;
  logic       wren, rden, br, req, ack, clr;
  logic       pc_en, o_to;
  logic [1:0] if_id_sel, id_ex_sel, ex_mem_sel, mem_wb_sel;
  logic [3:0] stall_cnt;

  typedef struct {
    string      name;
    logic       pc;
    logic [7:0] sels;
    logic       to;
    logic [3:0] cnt;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   n_vec = 0;
  int   n_fail = 0;
  int   cycles = 0;
  int   drain = 0;
  logic done = 1'b0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.TIMEOUT(4), .CNT_W(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .id_rs1_addr(rs1), .id_rs2_addr(rs2), .ex_rd_addr(rd),
    .ex_rd_wren(wren), .ex_mem_rden(rden), .ex_br_taken(br),
    .mem_req(req), .mem_ack(ack), .i_cnt_clr(clr),
    .pc_en(pc_en), .if_id_sel(if_id_sel), .id_ex_sel(id_ex_sel),
    .ex_mem_sel(ex_mem_sel), .mem_wb_sel(mem_wb_sel),
    .o_mem_timeout(o_to), .o_stall_cnt(stall_cnt)
  );

  task automatic vec(input string nm, input logic r, input logic [4:0] a1, input logic [4:0] a2,
                     input logic [4:0] d, input logic w, input logic l, input logic b,
                     input logic mr, input logic ma, input logic c,
                     input logic xpc, input logic [7:0] xs, input logic xto, input logic [3:0] xc);
    @(posedge clk);
    #1;
    rst_n = r; rs1 = a1; rs2 = a2; rd = d; wren = w; rden = l; br = b;
    req = mr; ack = ma; clr = c;
    q.push_back('{nm, xpc, xs, xto, xc});
  endtask

  // Monitor: one comparison per queued vector, plus drain and watchdog bounds
  always @(negedge clk) begin
    cycles <= cycles + 1;
    if (q.size() > 0) begin
      e = q.pop_front();
      n_vec <= n_vec + 1;
      if (pc_en !== e.pc || {if_id_sel, id_ex_sel, ex_mem_sel, mem_wb_sel} !== e.sels ||
          o_to !== e.to || stall_cnt !== e.cnt) begin
        n_fail <= n_fail + 1;
        $display("FAIL %s: got pc_en=%b sels=%b_%b_%b_%b to=%b cnt=%0d, want pc_en=%b sels=%b to=%b cnt=%0d",
                 e.name, pc_en, if_id_sel, id_ex_sel, ex_mem_sel, mem_wb_sel, o_to, stall_cnt,
                 e.pc, e.sels, e.to, e.cnt);
      end else begin
        $display("vec %s ok: pc_en=%b sels=%b_%b_%b_%b to=%b cnt=%0d",
                 e.name, pc_en, if_id_sel, id_ex_sel, ex_mem_sel, mem_wb_sel, o_to, stall_cnt);
      end
    end else if (done) begin
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
    end
    if (done && q.size() > 0) drain <= drain + 1;
    if (cycles > 2000 || drain > 20) begin
      $display("FAIL watchdog: got %0d cycles with %0d pending, want completion", cycles, q.size());
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail + 1);
      $finish;
    end
  end

  initial begin
    rst_n = 1'b0; rs1 = 0; rs2 = 0; rd = 0; wren = 0; rden = 0; br = 0;
    req = 0; ack = 0; clr = 0;
    //   name            rst rs1 rs2 rd  w  l  b  rq ak cl  pc sels to cnt
    vec("reset0",        0,  0,  0,  0,  0, 0, 0, 0, 0, 0,  0, RST, 0, 0);
    vec("reset1",        0,  0,  0,  0,  0, 0, 0, 0, 0, 0,  0, RST, 0, 0);
    vec("idle",          1,  0,  0,  0,  0, 0, 0, 0, 0, 0,  1, NOH, 0, 0);
    vec("lu_rs2",        1,  0,  5,  5,  1, 1, 0, 0, 0, 0,  0, LU,  0, 0);
    vec("lu_after",      1,  0,  0,  0,  0, 0, 0, 0, 0, 0,  1, NOH, 0, 1);
    vec("x0_exempt",     1,  0,  5,  0,  1, 1, 0, 0, 0, 0,  1, NOH, 0, 1);
    vec("lu_rs1",        1,  7,  0,  7,  1, 1, 0, 0, 0, 0,  0, LU,  0, 1);
    vec("no_wren",       1,  7,  0,  7,  0, 1, 0, 0, 0, 0,  1, NOH, 0, 2);
    vec("no_rden",       1,  7,  0,  7,  1, 0, 0, 0, 0, 0,  1, NOH, 0, 2);
    vec("br_beats_lu",   1,  0,  5,  5,  1, 1, 1, 0, 0, 0,  1, BR,  0, 2);
    vec("mw_c0",         1,  0,  0,  0,  0, 0, 0, 1, 0, 0,  0, MW,  0, 2);
    vec("mw_c1",         1,  0,  0,  0,  0, 0, 0, 1, 0, 0,  0, MW,  0, 3);
    vec("mw_c2",         1,  0,  0,  0,  0, 0, 0, 1, 0, 0,  0, MW,  0, 4);
    vec("mw_ack",        1,  0,  0,  0,  0, 0, 0, 1, 1, 0,  1, NOH, 0, 5);
    vec("after_ack",     1,  0,  0,  0,  0, 0, 0, 0, 0, 0,  1, NOH, 0, 5);
    vec("req_ack_same",  1,  0,  0,  0,  0, 0, 0, 1, 1, 0,  1, NOH, 0, 5);
    vec("mw_enter",      1,  0,  0,  0,  0, 0, 0, 1, 0, 0,  0, MW,  0, 5);
    vec("ack_then_lu",   1,  0,  3,  3,  1, 1, 0, 1, 1, 0,  0, LU,  0, 6);
    vec("idle2",         1,  0,  0,  0,  0, 0, 0, 0, 0, 0,  1, NOH, 0, 7);
    vec("to_c0",         1,  0,  0,  0,  0, 0, 0, 1, 0, 0,  0, MW,  0, 7);
    vec("to_c1",         1,  0,  0,  0,  0, 0, 0, 1, 0, 0,  0, MW,  0, 8);
    vec("to_c2",         1,  0,  0,  0,  0, 0, 0, 1, 0, 0,  0, MW,  0, 9);
    vec("to_c3",         1,  0,  0,  0,  0, 0, 0, 1, 0, 0,  0, MW,  0, 10);
    vec("to_fire",       1,  0,  0,  0,  0, 0, 0, 1, 0, 0,  1, TO,  1, 11);
    vec("to_back_run",   1,  0,  0,  0,  0, 0, 0, 0, 0, 0,  1, NOH, 0, 11);
    vec("tob_c0",        1,  0,  0,  0,  0, 0, 0, 1, 0, 0,  0, MW,  0, 11);
    vec("tob_c1",        1,  0,  0,  0,  0, 0, 0, 1, 0, 0,  0, MW,  0, 12);
    vec("tob_c2",        1,  0,  0,  0,  0, 0, 0, 1, 0, 0,  0, MW,  0, 13);
    vec("tob_c3",        1,  0,  0,  0,  0, 0, 0, 1, 0, 0,  0, MW,  0, 14);
    vec("to_with_br",    1,  0,  0,  0,  0, 0, 1, 1, 0, 0,  1, TOB, 1, 15);
    vec("idle3",         1,  0,  0,  0,  0, 0, 0, 0, 0, 0,  1, NOH, 0, 15);
    vec("lu_at_max",     1,  0,  9,  9,  1, 1, 0, 0, 0, 0,  0, LU,  0, 15);
    vec("cnt_saturated", 1,  0,  0,  0,  0, 0, 0, 0, 0, 0,  1, NOH, 0, 15);
    vec("clr_over_inc",  1,  0,  9,  9,  1, 1, 0, 0, 0, 1,  0, LU,  0, 15);
    vec("cnt_cleared",   1,  0,  0,  0,  0, 0, 0, 0, 0, 0,  1, NOH, 0, 0);
    vec("rw_c0",         1,  0,  0,  0,  0, 0, 0, 1, 0, 0,  0, MW,  0, 0);
    vec("rw_c1",         1,  0,  0,  0,  0, 0, 0, 1, 0, 0,  0, MW,  0, 1);
    vec("rst_mid_wait",  0,  0,  0,  0,  0, 0, 0, 1, 0, 0,  0, RST, 0, 2);
    vec("after_rst",     1,  0,  0,  0,  0, 0, 0, 0, 0, 0,  1, NOH, 0, 0);
    done = 1'b1;
  end

endmodule
